weapons_control_array: RTL and testbench

Parametrised multi-launcher successor to the single-channel weapons control unit. It arbitrates one shared missile magazine across `CHANNELS` launch tubes and supports single-shot and salvo firing, with round-robin tube selection. A post-fire cooldown and a timed reload sequence complete the engagement cycle. It sits between the targeting/lock logic and the launcher drivers, and exposes its magazine count and FSM state for telemetry.

---
 rtl/weapons_control_array.sv | 166 ++++++++++++++++
 tb/tb_weapons_control_array.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/weapons_control_array.sv
`default_nettype none
// ============================================================================
// Module      : weapons_control_array
// Description : Shared-magazine launcher controller with single-shot/salvo
//               firing, round-robin tube selection, cooldown and reload.
// Revision    : 1.0 - initial release
// ============================================================================
module weapons_control_array #(
    parameter int CHANNELS      = 4,
    parameter int MAG_WIDTH     = 4,
    parameter int MAG_INIT      = 4,
    parameter int SALVO_SIZE    = 3,
    parameter int COOLDOWN      = 3,
    parameter int RELOAD_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 target_locked,
    input  logic                 fire_command,
    input  logic                 salvo_mode,
    input  logic                 reload_request,
    output logic [CHANNELS-1:0]  launch_missile,
    output logic [MAG_WIDTH-1:0] remaining_missiles,
    output logic [2:0]           WCU_state
);

    localparam int c_ptr_w   = $clog2(CHANNELS);
    localparam int c_tmr_max = (COOLDOWN > RELOAD_CYCLES) ? COOLDOWN : RELOAD_CYCLES;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

    localparam logic [MAG_WIDTH-1:0] c_mag_init   = MAG_WIDTH'(MAG_INIT);
    localparam logic [MAG_WIDTH-1:0] c_salvo_size = MAG_WIDTH'(SALVO_SIZE);
    localparam logic [MAG_WIDTH-1:0] c_mag_one    = MAG_WIDTH'(1);
    localparam logic [c_ptr_w-1:0]   c_ptr_last   = c_ptr_w'(CHANNELS - 1);
    localparam logic [c_tmr_w-1:0]   c_tmr_cool   = c_tmr_w'(COOLDOWN);
    localparam logic [c_tmr_w-1:0]   c_tmr_reload = c_tmr_w'(RELOAD_CYCLES);
    localparam logic [c_tmr_w-1:0]   c_tmr_one    = c_tmr_w'(1);
    localparam logic [CHANNELS-1:0]  c_tube0      = CHANNELS'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOCKED   = 3'd1,
        ST_FIRE     = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_EMPTY    = 3'd4,
        ST_RELOAD   = 3'd5
    } state_t;

    state_t               r_state,  w_state_nxt;
    logic [CHANNELS-1:0]  r_launch, w_launch_nxt;
    logic [MAG_WIDTH-1:0] r_mag,    w_mag_nxt;
    logic [MAG_WIDTH-1:0] r_shots,  w_shots_nxt;
    logic [c_ptr_w-1:0]   r_ptr,    w_ptr_nxt;
    logic [c_tmr_w-1:0]   r_timer,  w_timer_nxt;

    logic [MAG_WIDTH-1:0] w_salvo_shots;
    logic [c_ptr_w-1:0]   w_ptr_inc;

    // Salvo length is clamped to the stock on hand so the magazine cannot underflow.
    assign w_salvo_shots = (r_mag < c_salvo_size) ? r_mag : c_salvo_size;
    assign w_ptr_inc     = (r_ptr == c_ptr_last) ? '0 : r_ptr + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_launch <= '0;
            r_mag    <= c_mag_init;
            r_shots  <= '0;
            r_ptr    <= '0;
            r_timer  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_launch <= w_launch_nxt;
            r_mag    <= w_mag_nxt;
            r_shots  <= w_shots_nxt;
            r_ptr    <= w_ptr_nxt;
            r_timer  <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_launch_nxt = '0;
        w_mag_nxt    = r_mag;
        w_shots_nxt  = r_shots;
        w_ptr_nxt    = r_ptr;
        w_timer_nxt  = r_timer;
        case (r_state)
            ST_IDLE: begin
                if (r_mag == '0) begin
                    w_state_nxt = ST_EMPTY;
                end else if (reload_request && (r_mag < c_mag_init)) begin
                    w_state_nxt = ST_RELOAD;
                    w_timer_nxt = c_tmr_reload;
                end else if (target_locked) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!target_locked) begin
                    w_state_nxt = ST_IDLE;
                end else if (fire_command) begin
                    w_state_nxt = ST_FIRE;
                    w_shots_nxt = salvo_mode ? w_salvo_shots : c_mag_one;
                end
            end
            ST_FIRE: begin
                if (target_locked) begin
                    w_launch_nxt = c_tube0 << r_ptr;
                    w_mag_nxt    = r_mag - c_mag_one;
                    w_ptr_nxt    = w_ptr_inc;
                    w_shots_nxt  = r_shots - c_mag_one;
                    if (r_shots <= c_mag_one) begin
                        w_shots_nxt = '0;
                        w_state_nxt = ST_COOLDOWN;
                        w_timer_nxt = c_tmr_cool;
                    end
                end else begin
                    // Lock lost: the rest of the salvo is dropped.
                    w_shots_nxt = '0;
                    w_state_nxt = ST_COOLDOWN;
                    w_timer_nxt = c_tmr_cool;
                end
            end
            ST_COOLDOWN: begin
                if (r_timer <= c_tmr_one) begin
                    w_timer_nxt = '0;
                    if (r_mag == '0) begin
                        w_state_nxt = ST_EMPTY;
                    end else if (target_locked) begin
                        w_state_nxt = ST_LOCKED;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer - c_tmr_one;
                end
            end
            ST_EMPTY: begin
                if (reload_request) begin
                    w_state_nxt = ST_RELOAD;
                    w_timer_nxt = c_tmr_reload;
                end
            end
            ST_RELOAD: begin
                if (r_timer <= c_tmr_one) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_IDLE;
                    w_mag_nxt   = c_mag_init;
                    w_ptr_nxt   = '0;
                end else begin
                    w_timer_nxt = r_timer - c_tmr_one;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign launch_missile     = r_launch;
    assign remaining_missiles = r_mag;
    assign WCU_state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_weapons_control_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_weapons_control_array
// Description : Randomised scoreboard bench for weapons_control_array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weapons_control_array;

    localparam int CHANNELS      = 4;
    localparam int MAG_WIDTH     = 4;
    localparam int MAG_INIT      = 4;
    localparam int SALVO_SIZE    = 3;
    localparam int COOLDOWN      = 3;
    localparam int RELOAD_CYCLES = 8;

    logic                 clk;
    logic                 rst;
    logic                 target_locked;
    logic                 fire_command;
    logic                 salvo_mode;
    logic                 reload_request;
    logic [CHANNELS-1:0]  launch_missile;
    logic [MAG_WIDTH-1:0] remaining_missiles;
    logic [2:0]           WCU_state;

    weapons_control_array #(
        .CHANNELS      (CHANNELS),
        .MAG_WIDTH     (MAG_WIDTH),
        .MAG_INIT      (MAG_INIT),
        .SALVO_SIZE    (SALVO_SIZE),
        .COOLDOWN      (COOLDOWN),
        .RELOAD_CYCLES (RELOAD_CYCLES)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .target_locked      (target_locked),
        .fire_command       (fire_command),
        .salvo_mode         (salvo_mode),
        .reload_request     (reload_request),
        .launch_missile     (launch_missile),
        .remaining_missiles (remaining_missiles),
        .WCU_state          (WCU_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int launch;
        int mag;
        int state;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   in_reset = 1'b1;

    // Reference: mode code, stock, next tube, tubes still planned for this
    // engagement, and the absolute cycle at which a timed phase ends.
    int m_mode, m_mag, m_next_tube, m_cyc, m_until, m_launch;
    int m_plan[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: one engagement-level update per rising edge.
    always @(posedge clk) begin
        if (!rst) begin
            m_mode = 0; m_mag = MAG_INIT; m_next_tube = 0;
            m_cyc = 0; m_until = 0; m_plan.delete();
        end else begin
            m_cyc++;
            m_launch = 0;
            case (m_mode)
                0: begin
                    if (m_mag == 0) m_mode = 4;
                    else if (reload_request && m_mag < MAG_INIT) begin
                        m_mode = 5; m_until = m_cyc + RELOAD_CYCLES;
                    end else if (target_locked) m_mode = 1;
                end
                1: begin
                    if (!target_locked) m_mode = 0;
                    else if (fire_command) begin
                        int n;
                        n = salvo_mode ? ((m_mag < SALVO_SIZE) ? m_mag : SALVO_SIZE) : 1;
                        for (int k = 0; k < n; k++) m_plan.push_back((m_next_tube + k) % CHANNELS);
                        m_mode = 2;
                    end
                end
                2: begin
                    if (target_locked) begin
                        int tube;
                        tube = m_plan.pop_front();
                        m_launch = 1 << tube;
                        m_mag = m_mag - 1;
                        m_next_tube = (tube + 1) % CHANNELS;
                    end else begin
                        m_plan.delete();
                    end
                    if (m_plan.size() == 0) begin
                        m_mode = 3; m_until = m_cyc + COOLDOWN;
                    end
                end
                3: begin
                    if (m_cyc == m_until)
                        m_mode = (m_mag == 0) ? 4 : (target_locked ? 1 : 0);
                end
                4: begin
                    if (reload_request) begin
                        m_mode = 5; m_until = m_cyc + RELOAD_CYCLES;
                    end
                end
                5: begin
                    if (m_cyc == m_until) begin
                        m_mode = 0; m_mag = MAG_INIT; m_next_tube = 0;
                    end
                end
                default: m_mode = 0;
            endcase
            exp_q.push_back('{launch: m_launch, mag: m_mag, state: m_mode});
        end
    end

    // Monitor: every cycle's registered outputs are compared to the scoreboard.
    always @(negedge clk) begin
        if (!in_reset) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("launch_missile", int'(launch_missile), e.launch);
                check("remaining_missiles", int'(remaining_missiles), e.mag);
                check("WCU_state", int'(WCU_state), e.state);
            end
        end
    end

    task automatic tick(input bit l, input bit f, input bit s, input bit r);
        @(negedge clk);
        #1;
        target_locked  = l;
        fire_command   = f;
        salvo_mode     = s;
        reload_request = r;
    endtask

    task automatic hold(input bit l, input int n);
        for (int i = 0; i < n; i++) tick(l, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_and_release();
        #1;
        check("rst_launch", int'(launch_missile), 0);
        check("rst_remaining", int'(remaining_missiles), MAG_INIT);
        check("rst_state", int'(WCU_state), 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst      = 1'b1;
        in_reset = 1'b0;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        in_reset = 1'b1;
        exp_q.delete();
        rst = 1'b0;
        check_reset_and_release();
    endtask

    initial begin
        rst = 1'b1;
        target_locked = 1'b0; fire_command = 1'b0; salvo_mode = 1'b0; reload_request = 1'b0;
        #1 rst = 1'b0;
        check_reset_and_release();

        // Single shot, then back to LOCKED after cooldown.
        hold(1'b1, 2);
        tick(1, 1, 0, 0); hold(1'b1, 6);
        // Salvo empties the magazine; fire requests in EMPTY do nothing.
        tick(1, 1, 1, 0); hold(1'b1, 8);
        repeat (3) tick(1, 1, 1, 0);
        // Reload, then a reload request in LOCKED is ignored.
        tick(0, 0, 0, 1); hold(1'b0, 10);
        hold(1'b1, 2);
        tick(1, 0, 0, 1); tick(1, 0, 0, 1);
        tick(1, 1, 0, 0); hold(1'b1, 5);
        // Second single leaves two rounds; salvo is clamped to two.
        tick(1, 1, 0, 0); hold(1'b1, 5);
        tick(1, 1, 1, 0); hold(1'b1, 8);
        repeat (2) tick(1, 1, 1, 0);
        // Reload, then abort a salvo after its first pulse.
        tick(0, 0, 0, 1); hold(1'b0, 10);
        hold(1'b1, 2);
        tick(1, 1, 1, 0); tick(1, 0, 0, 0);
        hold(1'b0, 6);
        // Asynchronous reset right after the first salvo pulse.
        hold(1'b1, 2);
        tick(1, 1, 1, 0); tick(1, 0, 0, 0);
        async_reset();

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset();
            tick($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
        end
        hold(1'b0, 4);

        @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
